// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Groups the hazard controller's pipeline-facing signals.
//               Hazard inputs come from IF/ID, ID/EX and MEM. Control outputs
//               go back to the fetch, decode and back-end stages.
//   master : hazard controller side (samples hazards, drives controls)
//   slave  : pipeline side (drives hazards, samples controls)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN = 64
);
  // Hazard sources
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [4:0]      ex_rd;
  logic            ex_mem_read;
  logic            ex_reg_write;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_target;
  logic            mem_req;
  logic            mem_ready;

  // Pipeline controls and status
  logic            stall_if;
  logic            flush_if;
  logic            stall_id;
  logic            flush_id;
  logic            freeze_back;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_target;
  logic [1:0]      state;
  logic [31:0]     stall_count;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_mem_read, ex_reg_write, ex_redirect, ex_target,
    input  mem_req, mem_ready,
    output stall_if, flush_if, stall_id, flush_id, freeze_back,
    output pc_redirect, pc_target, state, stall_count
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_mem_read, ex_reg_write, ex_redirect, ex_target,
    output mem_req, mem_ready,
    input  stall_if, flush_if, stall_id, flush_id, freeze_back,
    input  pc_redirect, pc_target, state, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Decode-stage hazard controller. Each cycle it decides whether
//               fetch / IF/ID advance, hold or are squashed, and whether
//               ID/EX advances, holds or takes a NOP bubble. It covers
//               load-use hazards, EX-resolved redirects and data-memory wait
//               states, and keeps a saturating stall-cycle counter.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   hz     : hazard inputs / control outputs (see pipeline_hazard_ctrl_if)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int XLEN = 64
) (
  input  wire logic               clk,
  input  wire logic               resetn,
  pipeline_hazard_ctrl_if.master  hz
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_REDIRECT   = 2'd3
  } state_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_e      state_q;
  state_e      state_d;
  logic        redir_pend_q;
  logic        redir_pend_d;
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  logic        freeze;
  logic        load_use;
  logic        redir_tail;

  logic        stall_if_c;
  logic        flush_if_c;
  logic        stall_id_c;
  logic        flush_id_c;
  logic        freeze_back_c;
  logic        pc_redirect_c;
  logic [XLEN-1:0] pc_target_c;

  // Hazard detection
  assign freeze   = hz.mem_req & ~hz.mem_ready;

  // x0 never carries a real dependency, so rd == 0 cannot cause a hazard.
  // This also lets the NOP bubble clear the hazard on its own.
  assign load_use = hz.id_valid & hz.ex_mem_read & hz.ex_reg_write &
                    (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // A redirect leaves one wrong-path fetch in flight. If a freeze hits while
  // that squash is due, redir_pend keeps it owed until the freeze exits.
  assign redir_tail = (state_q == ST_REDIRECT) |
                      ((state_q == ST_MEM_WAIT) & redir_pend_q);

  // Next-state and control decision, highest priority first
  always_comb begin
    state_d       = ST_RUN;
    redir_pend_d  = 1'b0;
    stall_if_c    = 1'b0;
    flush_if_c    = 1'b0;
    stall_id_c    = 1'b0;
    flush_id_c    = 1'b0;
    freeze_back_c = 1'b0;
    pc_redirect_c = 1'b0;

    if (freeze) begin
      // EX is held, so any redirect now is presented again after the freeze.
      stall_if_c    = 1'b1;
      stall_id_c    = 1'b1;
      freeze_back_c = 1'b1;
      state_d       = ST_MEM_WAIT;
      redir_pend_d  = redir_pend_q | (state_q == ST_REDIRECT);
    end else if (hz.ex_redirect) begin
      pc_redirect_c = 1'b1;
      flush_if_c    = 1'b1;
      flush_id_c    = 1'b1;
      state_d       = ST_REDIRECT;
    end else if (redir_tail) begin
      // The IF/ID content is wrong-path, so load-use is irrelevant here.
      flush_if_c    = 1'b1;
      state_d       = ST_RUN;
    end else if (load_use) begin
      stall_if_c    = 1'b1;
      flush_id_c    = 1'b1;
      state_d       = ST_LOAD_STALL;
    end else begin
      state_d       = ST_RUN;
    end
  end

  always_comb begin
    pc_target_c = '0;
    if (pc_redirect_c) begin
      pc_target_c = hz.ex_target;
    end
  end

  // Counts cycles in which fetch is held; saturates instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_if_c && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_RUN;
      redir_pend_q  <= 1'b0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      redir_pend_q  <= redir_pend_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Controls are Mealy outputs. They are gated by resetn so that nothing
  // is asserted while the pipeline is held in reset.
  assign hz.stall_if    = resetn & stall_if_c;
  assign hz.flush_if    = resetn & flush_if_c;
  assign hz.stall_id    = resetn & stall_id_c;
  assign hz.flush_id    = resetn & flush_id_c;
  assign hz.freeze_back = resetn & freeze_back_c;
  assign hz.pc_redirect = resetn & pc_redirect_c;
  assign hz.pc_target   = resetn ? pc_target_c : '0;
  assign hz.state       = state_q;
  assign hz.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl. Directed scenarios
//               are followed by random traffic. A reference model predicts
//               each cycle's outputs; a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int XLEN = 64;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  pipeline_hazard_ctrl_if #(.XLEN(XLEN)) bus ();

  pipeline_hazard_ctrl #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        preload;
    logic        id_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        mr;
    logic        rw;
    logic        redir;
    logic [63:0] tgt;
    logic        mreq;
    logic        mrdy;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        si;
    logic        fi;
    logic        sid;
    logic        fid;
    logic        fb;
    logic        pr;
    logic [63:0] pt;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;

  // Reference model state: architectural state number, whether a post-redirect
  // squash is still owed, and the stall count as a plain integer.
  int     m_state = 0;
  bit     m_owed  = 1'b0;
  longint m_count = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1; s.preload = 1'b0; s.id_valid = 1'b0;
    s.rs1 = 5'd0; s.rs2 = 5'd0; s.u1 = 1'b0; s.u2 = 1'b0;
    s.rd = 5'd0; s.mr = 1'b0; s.rw = 1'b0; s.redir = 1'b0;
    s.tgt = 64'd0; s.mreq = 1'b0; s.mrdy = 1'b0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    bit   frz;
    bit   lu;
    int   nstate;
    bit   nowed;
    @(negedge clk);
    cycle++;
    if (s.preload) force dut.stall_count_q = 32'hFFFF_FFFE;
    resetn          = s.rstn;
    bus.id_valid    = s.id_valid;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_uses_rs1 = s.u1;
    bus.id_uses_rs2 = s.u2;
    bus.ex_rd       = s.rd;
    bus.ex_mem_read = s.mr;
    bus.ex_reg_write= s.rw;
    bus.ex_redirect = s.redir;
    bus.ex_target   = s.tgt;
    bus.mem_req     = s.mreq;
    bus.mem_ready   = s.mrdy;
    #1;
    if (s.preload) begin
      release dut.stall_count_q;
      m_count = 64'h0000_0000_FFFF_FFFE;
    end
    e.cyc = cycle;
    e.si = 0; e.fi = 0; e.sid = 0; e.fid = 0; e.fb = 0; e.pr = 0; e.pt = 64'd0;
    if (!s.rstn) begin
      m_state = 0; m_owed = 1'b0; m_count = 0;
      e.st = 2'd0; e.cnt = 32'd0;
    end else begin
      e.st  = 2'(m_state);
      e.cnt = 32'(m_count);
      frz = s.mreq && !s.mrdy;
      lu  = s.id_valid && s.mr && s.rw && (s.rd != 0) &&
            ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (frz) begin
        e.si = 1; e.sid = 1; e.fb = 1; nstate = 2; nowed = m_owed;
      end else if (s.redir) begin
        e.pr = 1; e.fi = 1; e.fid = 1; e.pt = s.tgt; nstate = 3; nowed = 1'b1;
      end else if (m_owed) begin
        e.fi = 1; nstate = 0; nowed = 1'b0;
      end else if (lu) begin
        e.si = 1; e.fid = 1; nstate = 1; nowed = 1'b0;
      end else begin
        nstate = 0; nowed = 1'b0;
      end
      if (e.si) m_count = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
      m_state = nstate;
      m_owed  = nowed;
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int cyc, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_if",    e.cyc, 64'(bus.stall_if),    64'(e.si));
        chk("flush_if",    e.cyc, 64'(bus.flush_if),    64'(e.fi));
        chk("stall_id",    e.cyc, 64'(bus.stall_id),    64'(e.sid));
        chk("flush_id",    e.cyc, 64'(bus.flush_id),    64'(e.fid));
        chk("freeze_back", e.cyc, 64'(bus.freeze_back), 64'(e.fb));
        chk("pc_redirect", e.cyc, 64'(bus.pc_redirect), 64'(e.pr));
        chk("pc_target",   e.cyc, bus.pc_target,        e.pt);
        chk("state",       e.cyc, 64'(bus.state),       64'(e.st));
        chk("stall_count", e.cyc, 64'(bus.stall_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    stim_t lu_s;

    // Reset
    s = idle(); s.rstn = 1'b0;
    drive(s); drive(s);
    drive(idle()); drive(idle());

    // Load-use on rs1
    lu_s = idle();
    lu_s.id_valid = 1; lu_s.rs1 = 5'd5; lu_s.u1 = 1; lu_s.rd = 5'd5;
    lu_s.mr = 1; lu_s.rw = 1;
    drive(lu_s);
    s = lu_s; s.mr = 0; drive(s);
    drive(idle());

    // x0 and unused-operand immunity
    s = lu_s; s.rd = 5'd0; s.rs1 = 5'd0; drive(s);
    s = lu_s; s.rs1 = 5'd1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 0; drive(s);
    drive(idle());

    // Redirect, then redirect together with load-use
    s = idle(); s.redir = 1; s.tgt = 64'h0000_0000_8000_0040;
    drive(s); drive(idle()); drive(idle());
    s = lu_s; s.redir = 1; s.tgt = 64'h0000_0000_8000_0040;
    drive(s); drive(idle()); drive(idle());

    // Memory wait with a redirect held through the freeze
    s = idle(); s.mreq = 1; s.mrdy = 0; s.redir = 1; s.tgt = 64'h0000_0000_1234_5678;
    drive(s); drive(s); drive(s);
    s.mrdy = 1; drive(s);
    drive(idle()); drive(idle());

    // Freeze landing on the redirect tail
    s = idle(); s.redir = 1; s.tgt = 64'h0000_0000_0000_1000; drive(s);
    s = idle(); s.mreq = 1; s.mrdy = 0; drive(s); drive(s);
    s.mrdy = 1; drive(s);
    drive(idle()); drive(idle());

    // Counter saturation, then reset during a freeze
    s = idle(); s.mreq = 1; s.mrdy = 0; s.preload = 1; drive(s);
    s.preload = 0; drive(s); drive(s); drive(s);
    s.rstn = 0; drive(s);
    drive(idle()); drive(idle());

    // Random traffic with small register indices to make hazards common
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rstn     = ($urandom_range(0, 99) != 0);
      s.id_valid = ($urandom_range(0, 3) != 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.u1       = 1'($urandom);
      s.u2       = 1'($urandom);
      s.rd       = 5'($urandom_range(0, 3));
      s.mr       = 1'($urandom);
      s.rw       = ($urandom_range(0, 3) != 0);
      s.redir    = ($urandom_range(0, 5) == 0);
      s.tgt      = {$urandom, $urandom};
      s.mreq     = ($urandom_range(0, 3) == 0);
      s.mrdy     = 1'($urandom);
      drive(s);
    end
    drive(idle());

    repeat (2) @(negedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual %0d expected 0 entries left", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
